// File: rtl/bf_hazard_ctrl.sv
// bf_hazard_ctrl: hazard controller for the IF/ID field buffer and the ID/EX stage.
// Flush beats stall, and stall beats run. Stalls come from load-use and from the MULT/DIV busy tracker.
// The MULT/DIV tracker is a two-state FSM (IDLE/BUSY) with a down-counter.
// Its state is mirrored on md_state_dbg.
// Optional macro HZC_PERF_EN adds the saturating stall_cycles/flush_cycles counters.
//
// Handshake: this block has no valid/ready channel. Every control output is a
// same-cycle combinational function of the ID/EX inputs and the registered tracker state.
module bf_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk_bf_hazard_ctrl,
  input  logic             rst_bf_hazard_ctrl,
  input  logic [5:0]       op_id,
  input  logic [5:0]       funct_id,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic             md_state_dbg
`ifdef HZC_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_cycles
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;

  logic uses_rt, is_md, is_hilo, lu_hz, md_hz, stall, issue;

  // Decode the ID fields and form the hazard terms.
  always_comb begin
    uses_rt = (op_id == 6'h00) | (op_id == 6'h04) | (op_id == 6'h05) | (op_id == 6'h2B);
    is_md   = (op_id == 6'h00) &
              ((funct_id == 6'h18) | (funct_id == 6'h19) |
               (funct_id == 6'h1A) | (funct_id == 6'h1B));
    is_hilo = (op_id == 6'h00) & ((funct_id == 6'h10) | (funct_id == 6'h12));
    // A load into $0 produces nothing to wait for.
    lu_hz   = ex_mem_read & (ex_rt != 5'd0) &
              ((ex_rt == rs_id) | (uses_rt & (ex_rt == rt_id)));
    md_hz   = md_busy & (is_md | is_hilo);
    stall   = lu_hz | md_hz;
    // A squashed MULT/DIV never reaches the unit, so it must not start the counter.
    issue   = is_md & ~stall & ~branch_taken;
  end

  // Pipeline control outputs. Reset forces the flush/bubble pattern asynchronously.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst_bf_hazard_ctrl) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // MULT/DIV tracker next state. BUSY counts down whatever ID is doing,
  // because the issued operation has already left ID.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          md_cnt_nxt = CNT_W'(MD_LATENCY);
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        md_cnt_nxt = md_cnt - CNT_W'(1);
        if (md_cnt == CNT_W'(1)) state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Tracker state register with asynchronous clear.
  always_ff @(posedge clk_bf_hazard_ctrl or posedge rst_bf_hazard_ctrl) begin
    if (rst_bf_hazard_ctrl) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  assign md_busy      = (state == BUSY);
  assign md_state_dbg = state;

`ifdef HZC_PERF_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk_bf_hazard_ctrl or posedge rst_bf_hazard_ctrl) begin
    if (rst_bf_hazard_ctrl) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall & ~branch_taken & (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (branch_taken & (flush_cycles != 32'hFFFF_FFFF))
        flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bf_hazard_ctrl.sv
// Directed bench for bf_hazard_ctrl with MD_LATENCY=4.
// Inputs change 1ns after each rising edge. Outputs are sampled 3ns later, well before the next edge.
module tb_bf_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_id, funct_id;
  logic [4:0] rs_id, rt_id, ex_rt;
  logic       ex_mem_read, branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_state_dbg;
`ifdef HZC_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bf_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk_bf_hazard_ctrl(clk),
    .rst_bf_hazard_ctrl(rst),
    .op_id(op_id),
    .funct_id(funct_id),
    .rs_id(rs_id),
    .rt_id(rt_id),
    .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt),
    .branch_taken(branch_taken),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .md_busy(md_busy),
    .md_state_dbg(md_state_dbg)
`ifdef HZC_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  // Clock generation
  always #5 clk = ~clk;

  // Expected output patterns: {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;
  localparam logic [3:0] RESET = 4'b0011;

  // Wait for the next edge, then apply one set of ID/EX inputs.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                       input logic br);
    @(posedge clk);
    #1;
    op_id = op; funct_id = fn; rs_id = rs; rt_id = rt;
    ex_mem_read = mr; ex_rt = xrt; branch_taken = br;
  endtask

  // Compare the control outputs and the busy/state outputs against the expected values.
  task automatic check(input string tag, input logic [3:0] exp_ctl, input logic exp_busy);
    logic [5:0] obs, exp_v;
    #3;
    obs   = {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_state_dbg};
    exp_v = {exp_ctl, exp_busy, exp_busy};
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b (pc,ifw,flush,bubble,busy,state)", tag, obs, exp_v);
    end
  endtask

`ifdef HZC_PERF_EN
  task automatic check_perf(input string tag, input logic [31:0] exp_s, input logic [31:0] exp_f);
    n_checks++;
    assert ({stall_cycles, flush_cycles} === {exp_s, exp_f}) else begin
      n_errors++;
      $error("FAIL %s: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
             tag, stall_cycles, flush_cycles, exp_s, exp_f);
    end
  endtask
`endif

  initial begin
    // Reset held while a load-use match and a taken branch are both present.
    rst = 1'b1;
    op_id = 6'h00; funct_id = 6'h20; rs_id = 5'd8; rt_id = 5'd9;
    ex_mem_read = 1'b1; ex_rt = 5'd8; branch_taken = 1'b1;
    check("reset_outputs", RESET, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    op_id = 6'h00; funct_id = 6'h20; rs_id = 5'd0; rt_id = 5'd0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0;
    check("after_reset_run", RUN, 1'b0);

    // Load-use on rs: stall exactly one cycle, then the bubble clears EX.
    drive(6'h00, 6'h20, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0);
    check("loaduse_rs_stall", STALL, 1'b0);
    drive(6'h00, 6'h20, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0);
    check("loaduse_released", RUN, 1'b0);
    // A load into $0 never stalls.
    drive(6'h00, 6'h20, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    check("load_to_zero", RUN, 1'b0);

    // SW depends on rt. ADDI does not use rt as a source.
    drive(6'h2B, 6'h00, 5'd29, 5'd9, 1'b1, 5'd9, 1'b0);
    check("sw_rt_stall", STALL, 1'b0);
    drive(6'h08, 6'h00, 5'd29, 5'd9, 1'b1, 5'd9, 1'b0);
    check("addi_rt_no_stall", RUN, 1'b0);

    // A taken branch overrides a load-use stall.
    drive(6'h00, 6'h20, 5'd8, 5'd9, 1'b1, 5'd8, 1'b1);
    check("branch_beats_stall", FLUSH, 1'b0);

    // MULT issues at t. MFLO stalls t+1..t+4 and goes at t+5.
    drive(6'h00, 6'h18, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0);
    check("mult_issue", RUN, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      check($sformatf("mflo_stall_%0d", i), STALL, 1'b1);
    end
    drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("mflo_go", RUN, 1'b0);

    // DIVU issues, then a branch in the next cycle. The counter keeps running.
    drive(6'h00, 6'h1B, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0);
    check("divu_issue", RUN, 1'b0);
    drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    check("branch_while_busy", FLUSH, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      check($sformatf("mfhi_stall_%0d", i), STALL, 1'b1);
    end
    drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("mfhi_go", RUN, 1'b0);

    // Reset in mid-cycle while BUSY clears the tracker without a clock edge.
    drive(6'h00, 6'h18, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0);
    check("mult2_issue", RUN, 1'b0);
    drive(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    check("busy_before_reset", RUN, 1'b1);
    rst = 1'b1;
    check("async_reset_mid_busy", RESET, 1'b0);
    rst = 1'b0;
    check("after_async_reset", RUN, 1'b0);
    drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("mflo_after_reset", RUN, 1'b0);

    // A MULT squashed by a taken branch never starts the counter.
    drive(6'h00, 6'h18, 5'd8, 5'd9, 1'b0, 5'd0, 1'b1);
    check("mult_squashed", FLUSH, 1'b0);
`ifdef HZC_PERF_EN
    check_perf("perf_before_flush_edge", 32'd0, 32'd0);
`endif
    drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("mflo_after_squash", RUN, 1'b0);
`ifdef HZC_PERF_EN
    check_perf("perf_after_flush_edge", 32'd0, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bf_hazard_ctrl.md
Name: bf_hazard_ctrl

Overview:
Pipeline hazard controller that sequences the IF/ID field buffer and the ID/EX stage of the MIPS datapath. It consumes the decoded op/rs/rt/funct fields held in the IF/ID buffer plus EX-stage status. It drives PC write-enable, IF/ID write-enable, IF/ID flush and an ID/EX bubble. It detects load-use hazards, squashes wrong-path fetches on taken branches, and tracks a multi-cycle MULT/DIV unit so that HI/LO consumers stall until the result is ready.

Parameters:
MD_LATENCY, 4, cycles the MULT/DIV unit needs after issue before HI/LO are valid (1..15).
CNT_W, 4, width of the MULT/DIV busy counter; must hold MD_LATENCY.

Ports:
clk_bf_hazard_ctrl  input  1  single clock, rising edge.
rst_bf_hazard_ctrl  input  1  asynchronous, active-high reset.
op_id  input  6  opcode of the instruction in IF/ID.
funct_id  input  6  funct field of the instruction in IF/ID.
rs_id  input  5  rs field in IF/ID.
rt_id  input  5  rt field in IF/ID.
ex_mem_read  input  1  instruction in EX is a load (op 0x23).
ex_rt  input  5  destination rt of the instruction in EX.
branch_taken  input  1  branch/jump resolved taken in EX this cycle.
pc_write  output  1  PC register enable.
ifid_write  output  1  IF/ID buffer enable.
ifid_flush  output  1  IF/ID buffer loads a NOP (0x00000000).
idex_bubble  output  1  ID/EX control bits forced to zero.
md_busy  output  1  MULT/DIV counter non-zero.

Behaviour:
- Clock is the only clock; reset is asynchronous and active-high.
- While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_busy=0, md_cnt=0, state=IDLE.
- Control outputs are combinational from the current inputs and the registered md_cnt/state. They are valid in the same cycle as the inputs.
- uses_rt = (op_id==0x00) | (op_id==0x04) | (op_id==0x05) | (op_id==0x2B).
- is_md = op_id==0 & funct_id in {0x18,0x19,0x1A,0x1B}.
- is_hilo = op_id==0 & funct_id in {0x10,0x12}.
- lu_hz = ex_mem_read & ex_rt!=0 & (ex_rt==rs_id | (uses_rt & ex_rt==rt_id)).
- md_hz = md_busy & (is_md | is_hilo).
- stall = lu_hz | md_hz.
- Priority is flush > stall > run:
  - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Stall is ignored and md_cnt is not loaded, because the ID instruction is squashed.
  - stall (no branch): pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1. IF/ID contents hold.
  - otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Issue = is_md & !stall & !branch_taken.
- FSM, 2 states:
  - IDLE (md_cnt==0): on issue, load md_cnt=MD_LATENCY and go to BUSY.
  - BUSY: md_cnt decrements by 1 each edge. When md_cnt reaches 0, go to IDLE. Issue is impossible in BUSY because md_hz blocks it.
- md_busy = (state==BUSY).
- A HI/LO reader or a new MULT/DIV can leave ID in the first cycle md_cnt==0. With MD_LATENCY=4, a dependent MFLO placed directly after MULT stalls exactly 4 cycles.
- branch_taken while BUSY: the counter keeps decrementing, because the issued MULT/DIV already left ID.
- Reset mid-BUSY clears the counter immediately, without waiting for a clock edge.
- A load to $0 never stalls.
- Load-use stalls last exactly 1 cycle, because the bubble frees EX on the next edge.

Optional Feature:
HZC_PERF_EN:
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - Each increments on every edge where stall&!branch_taken, or where branch_taken, respectively.
  - Both saturate at 0xFFFFFFFF.
  - Both clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst with ex_mem_read=1 and branch_taken=1 → pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. Release → outputs follow RUN rules next cycle.
- Load-use: ex_mem_read=1, ex_rt=8; ID holds ADD $t2,$t0,$t1 (op 0, rs=8) → one cycle with pc_write=0, ifid_write=0, idex_bubble=1. Repeat with ex_rt=0 → no stall.
- Store rt dependency: ex_mem_read=1, ex_rt=9, ID holds SW (op 0x2B, rt=9, rs=29) → stall. Same rt with ADDI (op 0x08) → no stall.
- Branch beats stall: branch_taken=1 together with a load-use match → ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
- MULT then MFLO, MD_LATENCY=4: MULT issues at cycle t, MFLO in ID at t+1 → stall for cycles t+1..t+4, md_busy high for the same cycles, MFLO issues at t+5.
- MULT squashed: MULT in ID with branch_taken=1 → md_cnt stays 0 and md_busy stays 0. With HZC_PERF_EN defined, flush_cycles increments by 1.
